polyveck_make_hint_seq: RTL

Sequential controller that computes the Dilithium hint vector one coefficient per cycle. It streams the K×N coefficient pairs (v0, v1) out of the two coefficient RAMs and applies the per-coefficient make_hint rule. It emits the sparse hint encoding (poly index and coefficient index of every 1 bit, plus a cumulative count at each poly boundary) straight to the signature packer. The block also enforces the OMEGA bound and aborts with a reject flag as soon as the bound is exceeded.

---
 rtl/polyveck_make_hint_seq.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/polyveck_make_hint_seq.sv
// Dilithium make_hint sequencer: streams K*N (v0, v1) coefficient pairs out of
// the coefficient RAMs, evaluates one hint bit per cycle and emits the sparse
// hint encoding (positions of ones plus cumulative counts) for the packer.
// A pass aborts with reject as soon as the number of ones would exceed OMEGA.
module polyveck_make_hint_seq #(
    parameter int K      = 6,
    parameter int N      = 256,
    parameter int OMEGA  = 55,
    parameter int GAMMA2 = 261888,
    parameter int AW     = 11
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 rd_en,
    output logic [AW-1:0]        rd_addr,
    input  logic signed [31:0]   rd_v0,
    input  logic signed [31:0]   rd_v1,
    output logic                 hint_valid,
    output logic [2:0]           hint_poly,
    output logic [7:0]           hint_idx,
    output logic                 poly_done,
    output logic [2:0]           poly_done_idx,
    output logic [6:0]           hint_cnt,
    output logic                 busy,
    output logic                 done,
    output logic                 reject
);

    localparam logic signed [31:0] G_POS    = 32'(GAMMA2);
    localparam logic signed [31:0] G_NEG    = -G_POS;
    localparam logic [AW-1:0]      LAST_ADR = AW'(K * N - 1);
    localparam logic [7:0]         LAST_COF = 8'(N - 1);
    localparam logic [6:0]         CNT_MAX  = 7'(OMEGA);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_FIN,
        S_ABORT
    } state_t;

    state_t          state_q, state_d;

    logic            rd_en_q, rd_en_d;
    logic [AW-1:0]   rd_addr_q, rd_addr_d;
    logic [2:0]      rd_poly_q, rd_poly_d;
    logic [7:0]      rd_coef_q, rd_coef_d;
    logic            vld_p1_q, vld_p1_d;
    logic [2:0]      ev_poly_q, ev_poly_d;
    logic [7:0]      ev_coef_q, ev_coef_d;
    logic            hint_valid_q, hint_valid_d;
    logic [2:0]      hint_poly_q, hint_poly_d;
    logic [7:0]      hint_idx_q, hint_idx_d;
    logic            poly_done_q, poly_done_d;
    logic [2:0]      poly_done_idx_q, poly_done_idx_d;
    logic [6:0]      cnt_q, cnt_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            reject_q, reject_d;

    logic            start_acc;
    logic            eval;
    logic            hit;
    logic            ovf;
    logic            last_rd;

    // Per-coefficient hint rule; -GAMMA2 is the one boundary value whose hint depends on a1.
    function automatic logic make_hint(input logic signed [31:0] a0,
                                       input logic signed [31:0] a1);
        return (a0 > G_POS) || (a0 < G_NEG) || ((a0 == G_NEG) && (a1 != 32'sd0));
    endfunction

    // Qualifiers shared by the next-state and output logic.
    always_comb begin
        start_acc = start && (state_q == S_IDLE) && !busy_q;
        eval      = vld_p1_q && ((state_q == S_RUN) || (state_q == S_DRAIN));
        hit       = eval && make_hint(rd_v0, rd_v1);
        ovf       = hit && (cnt_q == CNT_MAX);
        last_rd   = (rd_addr_q == LAST_ADR);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; an overflow preempts every other transition.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_acc) state_d = S_RUN;
            S_RUN: begin
                if (ovf)          state_d = S_ABORT;
                else if (last_rd) state_d = S_DRAIN;
            end
            S_DRAIN: state_d = ovf ? S_ABORT : S_FIN;
            S_FIN:   state_d = S_IDLE;
            S_ABORT: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic: read sequencing, hint evaluation stage and pass status.
    always_comb begin
        rd_en_d         = 1'b0;
        rd_addr_d       = rd_addr_q;
        rd_poly_d       = rd_poly_q;
        rd_coef_d       = rd_coef_q;
        vld_p1_d        = rd_en_q;
        ev_poly_d       = rd_poly_q;
        ev_coef_d       = rd_coef_q;
        hint_valid_d    = 1'b0;
        hint_poly_d     = hint_poly_q;
        hint_idx_d      = hint_idx_q;
        poly_done_d     = 1'b0;
        poly_done_idx_d = poly_done_idx_q;
        cnt_d           = cnt_q;
        busy_d          = busy_q;
        done_d          = 1'b0;
        reject_d        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_acc) begin
                    rd_en_d   = 1'b1;
                    rd_addr_d = '0;
                    rd_poly_d = '0;
                    rd_coef_d = '0;
                    cnt_d     = '0;
                    busy_d    = 1'b1;
                end else if (done_q) begin
                    // busy covers the done cycle itself, then drops.
                    busy_d = 1'b0;
                end
            end
            S_RUN: begin
                if (!last_rd) begin
                    rd_en_d   = 1'b1;
                    rd_addr_d = rd_addr_q + AW'(1);
                    if (rd_coef_q == LAST_COF) begin
                        rd_coef_d = '0;
                        rd_poly_d = rd_poly_q + 3'd1;
                    end else begin
                        rd_coef_d = rd_coef_q + 8'd1;
                    end
                end
            end
            S_FIN: begin
                done_d = 1'b1;
            end
            S_ABORT: begin
                done_d   = 1'b1;
                reject_d = 1'b1;
            end
            default: ;
        endcase

        // The overflowing coefficient produces neither a hint nor a poly boundary.
        if (eval && !ovf) begin
            if (hit) begin
                hint_valid_d = 1'b1;
                hint_poly_d  = ev_poly_q;
                hint_idx_d   = ev_coef_q;
                cnt_d        = cnt_q + 7'd1;
            end
            if (ev_coef_q == LAST_COF) begin
                poly_done_d     = 1'b1;
                poly_done_idx_d = ev_poly_q;
            end
        end
    end

    // Datapath and status registers; a reset clears everything so a killed pass leaves no trace.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_en_q         <= 1'b0;
            rd_addr_q       <= '0;
            rd_poly_q       <= '0;
            rd_coef_q       <= '0;
            vld_p1_q        <= 1'b0;
            ev_poly_q       <= '0;
            ev_coef_q       <= '0;
            hint_valid_q    <= 1'b0;
            hint_poly_q     <= '0;
            hint_idx_q      <= '0;
            poly_done_q     <= 1'b0;
            poly_done_idx_q <= '0;
            cnt_q           <= '0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            reject_q        <= 1'b0;
        end else begin
            rd_en_q         <= rd_en_d;
            rd_addr_q       <= rd_addr_d;
            rd_poly_q       <= rd_poly_d;
            rd_coef_q       <= rd_coef_d;
            vld_p1_q        <= vld_p1_d;
            ev_poly_q       <= ev_poly_d;
            ev_coef_q       <= ev_coef_d;
            hint_valid_q    <= hint_valid_d;
            hint_poly_q     <= hint_poly_d;
            hint_idx_q      <= hint_idx_d;
            poly_done_q     <= poly_done_d;
            poly_done_idx_q <= poly_done_idx_d;
            cnt_q           <= cnt_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
            reject_q        <= reject_d;
        end
    end

    assign rd_en         = rd_en_q;
    assign rd_addr       = rd_addr_q;
    assign hint_valid    = hint_valid_q;
    assign hint_poly     = hint_poly_q;
    assign hint_idx      = hint_idx_q;
    assign poly_done     = poly_done_q;
    assign poly_done_idx = poly_done_idx_q;
    assign hint_cnt      = cnt_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign reject        = reject_q;

endmodule
